max7219_rx_decoder: RTL
=======================

MAX7219_RX_DECODER -- requirements
Module: max7219_rx_decoder

Interface
REQ-001 SHALL have parameter G_NB_MATRIX, default 8, number of daisy-chained devices decoded per frame (1..16).
REQ-002 SHALL have parameter G_SYNC_STAGES, default 2, synchronizer depth on the serial inputs (>=2).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_max7219_clk  in  1  serial clock from the transmitter, asynchronous to clk.
REQ-006 SHALL have port i_max7219_din  in  1  serial data, MSB first.
REQ-007 SHALL have port i_max7219_load  in  1  frame latch strobe; a rising edge ends a frame.
REQ-008 SHALL have port i_ready  in  1  downstream accepts the word on o_word_*.
REQ-009 SHALL have port o_word_valid  out  1  decoded word available.
REQ-010 SHALL have port o_word_matrix  out  4  device index, 0 = device nearest the transmitter.
REQ-011 SHALL have port o_word_addr  out  4  register address, D11..D8.
REQ-012 SHALL have port o_word_data  out  8  register data, D7..D0.
REQ-013 SHALL have port o_frame_done  out  1  one-cycle pulse after the last word of a frame is accepted.
REQ-014 SHALL have port o_frame_err  out  1  one-cycle pulse when a frame bit count differs from 16*G_NB_MATRIX.
REQ-015 SHALL have port o_overrun  out  1  one-cycle pulse when a frame ends while the previous frame is still being emitted.
REQ-016 SHALL have port o_busy  out  1  high while in S_EMIT.

Function
REQ-017 SHALL pass i_max7219_clk, i_max7219_din and i_max7219_load each through G_SYNC_STAGES flops, then detect rising edges with one further flop (edge latency G_SYNC_STAGES+1 clk cycles).
REQ-018 SHALL, on each synchronized serial-clock rising edge, shift synchronized din into the LSB of a 16*G_NB_MATRIX-bit shift register; bits leaving the MSB are discarded.
REQ-019 SHALL count shifted bits in a counter that saturates at 16*G_NB_MATRIX+1 and clears when a frame ends.
REQ-020 SHALL, when a serial-clock edge and a load edge are detected in the same cycle, shift that bit first and then end the frame including it.
REQ-021 SHALL, on a load edge with bit count == 16*G_NB_MATRIX in S_IDLE, copy the shift register to a frame buffer and enter S_EMIT.
REQ-022 SHALL, on a load edge with any other bit count, pulse o_frame_err, emit nothing and keep the current state; a load edge with count 0 SHALL also pulse o_frame_err.
REQ-023 SHALL, on a load edge in S_EMIT, pulse o_overrun, discard the new frame, clear the bit counter and continue the current emission.
REQ-024 SHALL use FSM states S_IDLE and S_EMIT; S_EMIT returns to S_IDLE in the cycle after the last handshake.
REQ-025 SHALL emit words in order matrix 0 .. G_NB_MATRIX-1; matrix k is frame-buffer bits [16k+15:16k], where bits [15:0] hold the last 16 bits shifted.
REQ-026 SHALL assert o_word_valid in S_EMIT starting the cycle after entry, hold o_word_* stable until i_ready is high, and advance one word per cycle while i_ready stays high.
REQ-027 SHALL pulse o_frame_done in the cycle after the final handshake and deassert o_word_valid in that same cycle.
REQ-028 SHALL ignore D15..D12 of each word.
REQ-029 SHALL keep shifting serial data in S_EMIT, so the next frame can be received during emission.

Reset
REQ-030 SHALL, while rst is high, clear all synchronizers, edge flops, shift register, counter and frame buffer, set state S_IDLE, and drive every output to 0.
REQ-031 SHALL, when rst asserts mid-frame or mid-emission, abandon all partial data; the first frame after release is decoded only if fully received after release.

Structure
REQ-032 SHALL place the state typedef, the word-width constant (16), and the address/data field positions in package max7219_pkg, shared with the transmitter side.
REQ-033 SHALL implement the synchronizer plus edge detector as one sub-module, max7219_sync_edge, instantiated three times.

Verification
REQ-034 SHALL cover: G_NB_MATRIX=8, 128 bits with matrix k = 0x0k00|(k+1) and i_ready=1 -> 8 consecutive words, addr=k, data=k+1, matrix=k, then o_frame_done.
REQ-035 SHALL cover: 127 bits then load -> o_frame_err pulse, no o_word_valid; 130 bits then load -> o_frame_err pulse.
REQ-036 SHALL cover: valid frame with i_ready toggling 1,0,0,1 -> o_word_* held during the stalls, no word lost or duplicated.
REQ-037 SHALL cover: i_ready=0 during emission, then a second full frame and load -> o_overrun pulse, first frame still emitted intact, second frame discarded.
REQ-038 SHALL cover: serial-clock edge and load edge coincident at bit 128 -> frame accepted including that bit.
REQ-039 SHALL cover: rst pulsed after 64 bits, then one full 128-bit frame -> exactly that frame decoded with no o_frame_err.

Source files
------------

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared types and word field positions for the MAX7219 serial link
package max7219_pkg;

  localparam int C_WORD_W   = 16;
  localparam int C_ADDR_LSB = 8;
  localparam int C_ADDR_W   = 4;
  localparam int C_DATA_LSB = 0;
  localparam int C_DATA_W   = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  function automatic logic [C_ADDR_W-1:0] word_addr(input logic [C_WORD_W-1:0] w);
    return w[C_ADDR_LSB +: C_ADDR_W];
  endfunction

  function automatic logic [C_DATA_W-1:0] word_data(input logic [C_WORD_W-1:0] w);
    return w[C_DATA_LSB +: C_DATA_W];
  endfunction

endpackage

// File: rtl/max7219_sync_edge.sv
// rtl/max7219_sync_edge.sv - multi-flop synchronizer with rising-edge detector
module max7219_sync_edge #(
  parameter int G_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [G_SYNC_STAGES-1:0] sync_q;
  logic                     prev_q;

  // Synchronizer chain followed by one delay flop used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[G_SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[G_SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[G_SYNC_STAGES-1];
  assign rise_o  = sync_q[G_SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/max7219_rx_decoder.sv
// rtl/max7219_rx_decoder.sv - deserializes daisy-chained MAX7219 frames into per-device words
module max7219_rx_decoder
  import max7219_pkg::*;
#(
  parameter int G_NB_MATRIX   = 8,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_max7219_clk,
  input  logic       i_max7219_din,
  input  logic       i_max7219_load,
  input  logic       i_ready,
  output logic       o_word_valid,
  output logic [3:0] o_word_matrix,
  output logic [3:0] o_word_addr,
  output logic [7:0] o_word_data,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int                 C_FRAME_BITS = C_WORD_W * G_NB_MATRIX;
  localparam int                 C_CNT_W      = $clog2(C_FRAME_BITS + 2);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL   = C_CNT_W'(C_FRAME_BITS);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT    = C_CNT_W'(C_FRAME_BITS + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
  localparam logic [3:0]         C_LAST_IDX   = 4'(G_NB_MATRIX - 1);

  logic sclk_rise, din_lvl, load_rise;
  logic sclk_lvl_unused, din_rise_unused, load_lvl_unused;

  logic [C_FRAME_BITS-1:0] shift_q, shift_d;
  logic [C_FRAME_BITS-1:0] frame_q, frame_d;
  logic [C_CNT_W-1:0]      cnt_q, cnt_d, cnt_shifted;
  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ovr_q, ovr_d;
  logic [C_WORD_W-1:0]     cur_word;

  max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(i_max7219_clk), .level_o(sclk_lvl_unused), .rise_o(sclk_rise)
  );

  max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst(rst), .d_i(i_max7219_din), .level_o(din_lvl), .rise_o(din_rise_unused)
  );

  max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst(rst), .d_i(i_max7219_load), .level_o(load_lvl_unused), .rise_o(load_rise)
  );

  // Shift in serial data; a coincident load sees the count including this bit
  always_comb begin
    shift_d     = shift_q;
    cnt_shifted = cnt_q;
    if (sclk_rise) begin
      shift_d = {shift_q[C_FRAME_BITS-2:0], din_lvl};
      if (cnt_q != C_CNT_SAT) begin
        cnt_shifted = cnt_q + C_CNT_ONE;
      end
    end
    cnt_d = load_rise ? '0 : cnt_shifted;
  end

  // Frame acceptance and word emission FSM, next-state and pulse outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_rise && (cnt_shifted == C_CNT_FULL)) begin
          frame_d = shift_d;
          idx_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (i_ready) begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_rise) begin
      if (cnt_shifted != C_CNT_FULL) begin
        err_d = 1'b1;
      end else if (state_q == S_EMIT) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, datapath and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Select the frame-buffer slice for the device currently being emitted
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < G_NB_MATRIX; k++) begin
      if (idx_q == 4'(k)) begin
        cur_word = frame_q[k*C_WORD_W +: C_WORD_W];
      end
    end
  end

  assign o_word_valid  = (state_q == S_EMIT);
  assign o_busy        = (state_q == S_EMIT);
  assign o_word_matrix = o_word_valid ? idx_q : 4'd0;
  assign o_word_addr   = o_word_valid ? word_addr(cur_word) : 4'd0;
  assign o_word_data   = o_word_valid ? word_data(cur_word) : 8'd0;
  assign o_frame_done  = done_q;
  assign o_frame_err   = err_q;
  assign o_overrun     = ovr_q;

endmodule
